// File: rtl/c_hazard_unit.sv
// c_hazard_unit: hazard controller for the 5-stage core.
// It produces the stall, flush and forwarding controls for the IF/ID, ID/EX and
// EX/MEM registers. A small FSM holds a multi-cycle mul/div op in EX for
// LATENCY cycles.
module c_hazard_unit #(
    parameter int LATENCY = 4,  // total EX-hold cycles of a mul/div op (2..15)
    parameter int CW      = 4   // counter width; must hold LATENCY-1
) (
    input  logic       clk,
    input  logic       reset,       // asynchronous, active-low
    input  logic [4:0] rs1d,
    input  logic [4:0] rs2d,
    input  logic [4:0] rs1e,
    input  logic [4:0] rs2e,
    input  logic [4:0] rde,
    input  logic [4:0] rdm,
    input  logic [4:0] rdw,
    input  logic [1:0] resultsrce,
    input  logic       regwritem,
    input  logic       regwritew,
    input  logic       pcsrce,
    input  logic       mdstarte,
    output logic [1:0] forwardae,
    output logic [1:0] forwardbe,
    output logic       stallf,
    output logic       stalld,
    output logic       stalle,
    output logic       flushd,
    output logic       flushe,
    output logic       flushm,
    output logic       mdbusy,
    output logic       mddone
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    md_state_t     state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          lwstall;
    logic          mdstall;

    // Operand forwarding: the younger MEM-stage result wins over WB; x0 never forwards.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        forwardae = 2'b00;
        forwardbe = 2'b00;
        if (regwritem && (rdm != 5'd0) && (rdm == rs1e))
            forwardae = 2'b10;
        else if (regwritew && (rdw != 5'd0) && (rdw == rs1e))
            forwardae = 2'b01;
        if (regwritem && (rdm != 5'd0) && (rdm == rs2e))
            forwardbe = 2'b10;
        else if (regwritew && (rdw != 5'd0) && (rdw == rs2e))
            forwardbe = 2'b01;
    end

    // A load in EX whose destination is read in ID must wait one cycle.
    assign lwstall = (resultsrce == 2'b01) && (rde != 5'd0) &&
                     ((rde == rs1d) || (rde == rs2d));

    // The front end is held while a mul/div op sits in EX, except in its DONE cycle.
    assign mdstall = mdstarte && (state != DONE);

    // Mul/div sequencer state register; reset abandons any op in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Mul/div next-state logic: count down the hold cycles, abort if the op leaves EX.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (mdstarte) begin
                    state_next = BUSY;
                    cnt_next   = CW'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (!mdstarte) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CW'(1)) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            DONE: begin
                // The result is consumed this cycle; a still-high mdstarte
                // belongs to this op and must not restart the sequencer.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Pipeline control outputs. A held mul/div op blocks the ID/EX clear so it
    // survives an (illegal) simultaneous redirect.
    assign stallf = lwstall | mdstall;
    assign stalld = lwstall | mdstall;
    assign stalle = mdstall;
    assign flushm = mdstall;
    assign flushd = pcsrce;
    assign flushe = (lwstall | pcsrce) & ~mdstall;
    assign mdbusy = (state == BUSY);
    assign mddone = (state == DONE);

endmodule

// File: tb/tb_c_hazard_unit.sv
// tb_c_hazard_unit: directed and randomized checks of c_hazard_unit against a
// reference model that tracks a mul/div op as a count of elapsed EX cycles.
module tb_c_hazard_unit;

    localparam int LATENCY = 4;
    localparam int CW      = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] resultsrce;
    logic       regwritem, regwritew, pcsrce, mdstarte;
    logic [1:0] forwardae, forwardbe;
    logic       stallf, stalld, stalle, flushd, flushe, flushm, mdbusy, mddone;

    int compared   = 0;
    int mismatched = 0;
    // Cycles the current mul/div op has already spent in EX (0 = no op running).
    int held       = 0;

    c_hazard_unit #(.LATENCY(LATENCY), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .rs1d       (rs1d),
        .rs2d       (rs2d),
        .rs1e       (rs1e),
        .rs2e       (rs2e),
        .rde        (rde),
        .rdm        (rdm),
        .rdw        (rdw),
        .resultsrce (resultsrce),
        .regwritem  (regwritem),
        .regwritew  (regwritew),
        .pcsrce     (pcsrce),
        .mdstarte   (mdstarte),
        .forwardae  (forwardae),
        .forwardbe  (forwardbe),
        .stallf     (stallf),
        .stalld     (stalld),
        .stalle     (stalle),
        .flushd     (flushd),
        .flushe     (flushe),
        .flushm     (flushm),
        .mdbusy     (mdbusy),
        .mddone     (mddone)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] observed, input logic [1:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (regwritem && rdm != 0 && rdm == rs) return 2'd2;
        if (regwritew && rdw != 0 && rdw == rs) return 2'd1;
        return 2'd0;
    endfunction

    // Compare every output against the model built from the current inputs and op age.
    task automatic check_all(input string tag);
        logic lw, md, done, busy;
        lw   = (resultsrce == 2'b01) && rde != 0 && (rde == rs1d || rde == rs2d);
        done = (held == LATENCY);
        busy = (held > 0) && (held < LATENCY);
        md   = mdstarte && !done;
        check({tag, ".fwda"},   forwardae, ref_fwd(rs1e));
        check({tag, ".fwdb"},   forwardbe, ref_fwd(rs2e));
        check({tag, ".stallf"}, {1'b0, stallf}, {1'b0, lw | md});
        check({tag, ".stalld"}, {1'b0, stalld}, {1'b0, lw | md});
        check({tag, ".stalle"}, {1'b0, stalle}, {1'b0, md});
        check({tag, ".flushm"}, {1'b0, flushm}, {1'b0, md});
        check({tag, ".flushd"}, {1'b0, flushd}, {1'b0, pcsrce});
        check({tag, ".flushe"}, {1'b0, flushe}, {1'b0, (lw | pcsrce) & !md});
        check({tag, ".mdbusy"}, {1'b0, mdbusy}, {1'b0, busy});
        check({tag, ".mddone"}, {1'b0, mddone}, {1'b0, done});
    endtask

    // Advance one clock: age the op, then move to 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        if (!reset)                held = 0;
        else if (held == LATENCY)  held = 0;
        else if (mdstarte)         held = held + 1;
        else                       held = 0;
        #1;
    endtask

    // Inputs are already applied; check mid-cycle, then clock.
    task automatic step(input string tag);
        #4;
        check_all(tag);
        tick();
    endtask

    task automatic clear_inputs();
        rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
        resultsrce = 2'b00; regwritem = 0; regwritew = 0; pcsrce = 0; mdstarte = 0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset state: FSM idle even with a mul/div op presented; stalls follow inputs.
        mdstarte = 1'b1;
        #4;
        check("rst.mdbusy", {1'b0, mdbusy}, 2'd0);
        check("rst.mddone", {1'b0, mddone}, 2'd0);
        check("rst.stalle", {1'b0, stalle}, 2'd1);
        check_all("rst");
        tick();
        clear_inputs();
        reset = 1'b1;
        step("idle");

        // Forwarding priority: MEM over WB, then WB once MEM targets x0.
        rdm = 5; regwritem = 1; rs1e = 5; rdw = 5; regwritew = 1; rs2e = 5;
        #4;
        check("fwd.mem_wins", forwardae, 2'b10);
        check_all("fwd1");
        tick();
        rdm = 0;
        #4;
        check("fwd.wb", forwardae, 2'b01);
        check_all("fwd2");
        tick();
        rdw = 0;
        step("fwd.x0");
        clear_inputs();

        // Load-use stall, then the same with an x0 destination.
        resultsrce = 2'b01; rde = 7; rs2d = 7;
        #4;
        check("lw.stallf", {1'b0, stallf}, 2'd1);
        check("lw.flushe", {1'b0, flushe}, 2'd1);
        check_all("lw1");
        tick();
        rde = 0; rs2d = 0;
        #4;
        check("lw.x0_stall", {1'b0, stallf}, 2'd0);
        check_all("lw2");
        tick();
        clear_inputs();

        // Taken branch: flush both front registers, no stall.
        pcsrce = 1'b1;
        #4;
        check("br.flushd", {1'b0, flushd}, 2'd1);
        check("br.flushe", {1'b0, flushe}, 2'd1);
        check("br.stallf", {1'b0, stallf}, 2'd0);
        tick();
        pcsrce = 1'b0;
        step("br.after");

        // Two back-to-back mul/div ops: 4 stall cycles then one DONE cycle each.
        mdstarte = 1'b1;
        for (int i = 0; i < 2 * (LATENCY + 1); i++) begin
            #4;
            check($sformatf("md.stall%0d", i), {1'b0, stalle}, {1'b0, (i % (LATENCY + 1)) != LATENCY});
            check($sformatf("md.done%0d", i), {1'b0, mddone}, {1'b0, (i % (LATENCY + 1)) == LATENCY});
            check_all($sformatf("md%0d", i));
            tick();
        end
        mdstarte = 1'b0;
        step("md.idle");

        // Illegal redirect while an op is held: flushd stays, flushe suppressed.
        mdstarte = 1'b1; pcsrce = 1'b1;
        #4;
        check("ill.flushd", {1'b0, flushd}, 2'd1);
        check("ill.flushe", {1'b0, flushe}, 2'd0);
        tick();
        pcsrce = 1'b0; mdstarte = 1'b0;
        step("ill.abort");

        // Reset mid-BUSY (cnt=2) abandons the op; a full op follows after release.
        mdstarte = 1'b1;
        step("rb0");
        step("rb1");
        reset = 1'b0;
        held  = 0;
        #1;
        check("rb.mdbusy_now", {1'b0, mdbusy}, 2'd0);
        #3;
        check_all("rb.inreset");
        tick();
        reset = 1'b1;
        for (int i = 0; i <= LATENCY; i++) begin
            #4;
            check($sformatf("rb.stall%0d", i), {1'b0, stallf}, {1'b0, i != LATENCY});
            check_all($sformatf("rb%0d", i));
            tick();
        end
        clear_inputs();

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            rs1d = 5'($urandom_range(0, 3));
            rs2d = 5'($urandom_range(0, 3));
            rs1e = 5'($urandom_range(0, 3));
            rs2e = 5'($urandom_range(0, 3));
            rde  = 5'($urandom_range(0, 3));
            rdm  = 5'($urandom_range(0, 3));
            rdw  = 5'($urandom_range(0, 3));
            resultsrce = 2'($urandom_range(0, 3));
            regwritem  = 1'($urandom_range(0, 1));
            regwritew  = 1'($urandom_range(0, 1));
            pcsrce     = ($urandom_range(0, 9) == 0);
            mdstarte   = ($urandom_range(0, 9) < 6);
            step($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
